// File: rtl/deserializer.sv
// deserializer: serial-to-parallel receiver for the serializer frame format
// (start bit 1, DATA_WIDTH data bits MSB first, stop bit 0, line idles 0).
// Received words are held in a one-entry register with a valid/ready
// handshake; framing errors and overruns are reported as one-cycle pulses.
module deserializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STOP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_frame_error;
    logic                  r_overrun;

    logic w_accept;
    logic w_last_bit;
    logic w_room;

    // Consumer takes the held word this cycle
    assign w_accept   = r_valid & ready;
    // Current SHIFT cycle samples the final data bit
    assign w_last_bit = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    // Holding register can take a new word (empty, or emptied this cycle)
    assign w_room     = ~r_valid | ready;

    // Frame FSM, shift register, holding register and status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sr          <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;

            // A handshake empties the holder; a load in STOP below overrides it
            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (data_in) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= {r_sr[DATA_WIDTH-2:0], data_in};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (data_in) begin
                        r_frame_error <= 1'b1;
                    end else if (w_room) begin
                        r_data  <= r_sr;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign valid       = r_valid;
    assign busy        = r_busy;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_deserializer.sv
// Directed testbench for deserializer (DATA_WIDTH = 8).
module tb_deserializer;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         data_in = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;
    logic         frame_error;
    logic         overrun;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int fe_cnt     = 0;
    int ov_cnt     = 0;
    int both_cnt   = 0;

    deserializer #(.DATA_WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (frame_error && overrun) both_cnt <= both_cnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full frame; returns with the cycle after the stop bit current.
    task automatic send_frame(input logic [W-1:0] w, input logic stop_bit,
                              input logic ready_on_stop, output int busy_cycles);
        busy_cycles = 0;
        data_in = 1'b1;
        tick;
        if (busy) busy_cycles++;
        for (int i = 0; i < int'(W); i++) begin
            data_in = w[W-1-i];
            tick;
            if (busy) busy_cycles++;
        end
        data_in = stop_bit;
        if (ready_on_stop) ready = 1'b1;
        tick;
        data_in = 1'b0;
        if (ready_on_stop) ready = 1'b0;
    endtask

    initial begin
        int bc;
        int t1;
        int fe0;
        int ov0;

        // Reset
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fe", 32'(frame_error), 32'h0);
        check("rst_ov", 32'(overrun), 32'h0);
        tick;

        // Single frame 9E, ready low
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h9E, 1'b0, 1'b0, bc);
        check("f1_busy_cycles", 32'(bc), 32'd9);
        check("f1_busy_after", 32'(busy), 32'h0);
        check("f1_valid", 32'(valid), 32'h1);
        check("f1_data", 32'(data_out), 32'h9E);
        tick;
        check("f1_valid_hold", 32'(valid), 32'h1);
        check("f1_data_hold", 32'(data_out), 32'h9E);
        ready = 1'b1;
        tick;
        ready = 1'b0;
        check("f1_valid_cleared", 32'(valid), 32'h0);
        check("f1_data_kept", 32'(data_out), 32'h9E);
        check("f1_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        tick;

        // Back-to-back A5 then 3C, ready high
        fe0 = fe_cnt; ov0 = ov_cnt;
        ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, bc);
        check("b2b_valid1", 32'(valid), 32'h1);
        check("b2b_data1", 32'(data_out), 32'hA5);
        t1 = cyc;
        send_frame(8'h3C, 1'b0, 1'b0, bc);
        check("b2b_valid2", 32'(valid), 32'h1);
        check("b2b_data2", 32'(data_out), 32'h3C);
        check("b2b_spacing", 32'(cyc - t1), 32'd10);
        tick;
        ready = 1'b0;
        check("b2b_drained", 32'(valid), 32'h0);
        check("b2b_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        tick;

        // Overrun: 11 held, 22 dropped
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b0, bc);
        check("ov_first", 32'(data_out), 32'h11);
        send_frame(8'h22, 1'b0, 1'b0, bc);
        check("ov_pulse", 32'(overrun), 32'h1);
        check("ov_no_fe", 32'(frame_error), 32'h0);
        check("ov_data", 32'(data_out), 32'h11);
        check("ov_valid", 32'(valid), 32'h1);
        tick;
        check("ov_pulse_end", 32'(overrun), 32'h0);
        check("ov_count", 32'(ov_cnt - ov0), 32'd1);
        check("ov_data_hold", 32'(data_out), 32'h11);
        ready = 1'b1;
        tick;
        ready = 1'b0;
        check("ov_drained", 32'(valid), 32'h0);
        tick;

        // Simultaneous accept on the second frame's stop cycle
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b0, bc);
        check("sa_first", 32'(data_out), 32'h11);
        send_frame(8'h22, 1'b0, 1'b1, bc);
        check("sa_data", 32'(data_out), 32'h22);
        check("sa_valid", 32'(valid), 32'h1);
        check("sa_no_ov", 32'(overrun), 32'h0);
        tick;
        check("sa_ov_count", 32'(ov_cnt - ov0), 32'd0);
        ready = 1'b1;
        tick;
        ready = 1'b0;
        check("sa_drained", 32'(valid), 32'h0);
        tick;

        // Framing error: FF with stop bit 1, then good 01
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, bc);
        check("fe_pulse", 32'(frame_error), 32'h1);
        check("fe_no_ov", 32'(overrun), 32'h0);
        check("fe_valid", 32'(valid), 32'h0);
        tick;
        check("fe_pulse_end", 32'(frame_error), 32'h0);
        check("fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("fe_busy", 32'(busy), 32'h0);
        send_frame(8'h01, 1'b0, 1'b0, bc);
        check("fe_next_valid", 32'(valid), 32'h1);
        check("fe_next_data", 32'(data_out), 32'h01);
        tick;

        // Reset after 4 data bits; holding register (01) must clear
        fe0 = fe_cnt; ov0 = ov_cnt;
        data_in = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            data_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick;
        end
        check("mr_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        data_in = 1'b0;
        tick;
        reset = 1'b0;
        check("mr_valid", 32'(valid), 32'h0);
        check("mr_data", 32'(data_out), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_fe", 32'(frame_error), 32'h0);
        check("mr_ov", 32'(overrun), 32'h0);
        tick;
        tick;
        check("mr_idle", 32'(busy), 32'h0);
        send_frame(8'hC3, 1'b0, 1'b0, bc);
        check("mr_c3_valid", 32'(valid), 32'h1);
        check("mr_c3_data", 32'(data_out), 32'hC3);
        check("mr_c3_busy", 32'(bc), 32'd9);
        tick;
        check("mr_no_err", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel receiver that sits directly downstream of `serializer`, consuming its one-bit-per-clock `data_out` stream and reassembling `DATA_WIDTH`-bit words. It detects a start bit, shifts in the data bits MSB first, checks the stop bit, and presents each word through a one-entry holding register with a valid/ready handshake. Framing errors and overruns are flagged as single-cycle pulses for the system controller.

## Interface
- `DATA_WIDTH`, default 8: word width in bits; minimum 2.
- `clock` input 1: sole clock; all logic samples on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data_in` input 1: serial line from `serializer.data_out`; idles low.
- `data_out` output `DATA_WIDTH`: received word; valid only while `valid`=1.
- `valid` output 1: holding register contains an unconsumed word.
- `ready` input 1: consumer accepts the word on a cycle where `valid`&`ready`=1.
- `busy` output 1: frame reception in progress (SHIFT or STOP state).
- `frame_error` output 1: one-cycle pulse; stop bit was 1, frame dropped.
- `overrun` output 1: one-cycle pulse; good frame dropped because holding register was full.

## Operation
- Frame format, one bit per clock: start bit 1, then `DATA_WIDTH` data bits MSB first, then stop bit 0. Line idles 0.
- State machine: IDLE, SHIFT, STOP.
  - IDLE: `data_in`=1 → SHIFT, bit counter cleared to 0. `data_in`=0 → stay.
  - SHIFT: shift `data_in` into the LSB of the shift register (`{sr[W-2:0], data_in}`), increment counter; after the `DATA_WIDTH`-th bit → STOP.
  - STOP: sample the stop bit, then → IDLE unconditionally.
- STOP with `data_in`=0 (good frame):
  - If `valid`=0, or `valid`&`ready`=1 in the same cycle, load the shift register into `data_out` and set `valid`=1.
  - Otherwise keep the old word, discard the new one, and pulse `overrun`.
- STOP with `data_in`=1: discard the word, pulse `frame_error`; holding register unchanged.
- A `valid`&`ready` handshake with no load clears `valid`. `data_out` holds its value until the next load.
- Bit counter width is `$clog2(DATA_WIDTH+1)`; the counter never wraps within a frame.
- Back-to-back frames are supported: a start bit on the cycle immediately after STOP is accepted from IDLE.

## Timing
- Reset values:
  - `valid`=0, `data_out`=0, `busy`=0, `frame_error`=0, `overrun`=0.
  - State IDLE, counter 0, shift register 0.
- Reset asserted mid-frame aborts the frame and clears the holding register. No error pulse is produced.
- Start bit sampled at edge t. Data bits are sampled at t+1 … t+W. Stop bit is sampled at t+W+1.
- `busy`=1 during cycles t+1 … t+W+1, and 0 otherwise.
- `valid` (or `frame_error` / `overrun`) rises after edge t+W+1, i.e. visible in cycle t+W+2. Latency from start bit to `valid` is W+2 cycles.
- Minimum frame period is W+2 cycles. Sustained full rate needs `ready`=1 in each cycle in which a load would occur.
- `frame_error` and `overrun` are high for exactly one cycle and are never both high.
- `data_out` and `valid` are stable while `valid`=1 and `ready`=0.
- `ready` is ignored when `valid`=0.

## Test plan
- Single frame, W=8, `ready`=0: drive 1, 1,0,0,1,1,1,1,0, then 0. Required: `data_out`=8'h9E, `valid`=1 in cycle t+10, and `busy` high for 9 cycles. Raise `ready` for one cycle → `valid`=0.
- Back-to-back frames 8'hA5 then 8'h3C with no idle gap and `ready`=1. Required: both words appear in order, exactly 10 cycles apart, with no error pulses.
- Overrun: receive 8'h11 with `ready`=0, then 8'h22. Required: `overrun` pulses once, and `data_out` stays 8'h11 with `valid`=1.
- Simultaneous accept: repeat the overrun case with `ready`=1 exactly on the second frame's STOP cycle. Required: `data_out`=8'h22, `valid`=1, and no `overrun`.
- Framing error: frame 8'hFF with stop bit 1. Required: `frame_error` is a single-cycle pulse, `valid` stays 0, and the next good frame 8'h01 is received correctly.
- Reset mid-frame: assert `reset` for 1 cycle after 4 data bits. Required: all outputs at reset values and the state returns to IDLE. A following full frame 8'hC3 is received correctly with no error pulses.
